// File: rtl/aes64_mixcol_unit.sv
// aes64_mixcol_unit
//   Processes one AES round for a 64-bit half-state, which holds two columns.
//   Each column gets MixColumns, or the identity on the final round. The
//   result is then XORed with the round key. The unit works on one column
//   per cycle.
//
// Parameters
//   KEY_XOR    1: XOR the round key into the result; 0: ignore in_key
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_key / in_last are valid
//   in_ready   unit can accept an input (IDLE, or DONE while out_ready)
//   in_data    state half: column0 = [31:0], column1 = [63:32], row r = byte r
//   in_key     round-key half, same layout as in_data
//   in_last    final round: MixColumns bypassed, key XOR still applied
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data
//   out_data   registered result, same layout as in_data
module aes64_mixcol_unit #(
  parameter bit KEY_XOR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COL0 = 2'd1;
  localparam logic [1:0] COL1 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [63:0] data_q;
  logic [63:0] key_q;
  logic        last_q;
  logic        accept;
  logic [31:0] col_in;
  logic [31:0] key_col;
  logic [31:0] col_res;

  // GF(2^8) multiply by 2 with reduction by the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    b0 = c[7:0];
    b1 = c[15:8];
    b2 = c[23:16];
    b3 = c[31:24];
    r0 = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
    r1 = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
    r2 = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
    r3 = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
    return {r3, r2, r1, r0};
  endfunction

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // One shared column datapath; the state selects which column it processes.
  always_comb begin
    col_in  = (state == COL1) ? data_q[63:32] : data_q[31:0];
    key_col = (state == COL1) ? key_q[63:32]  : key_q[31:0];
    col_res = (last_q ? col_in : mixcol(col_in)) ^ key_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      key_q    <= '0;
      last_q   <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= COL0;
        end
        COL0: begin
          out_data[31:0] <= col_res;
          state          <= COL1;
        end
        COL1: begin
          out_data[63:32] <= col_res;
          state           <= DONE;
        end
        default: begin
          if (out_ready) state <= in_valid ? COL0 : IDLE;
        end
      endcase
      if (accept) begin
        data_q <= in_data;
        key_q  <= KEY_XOR ? in_key : '0;
        last_q <= in_last;
      end
    end
  end

endmodule
